// File: rtl/riscn_core.sv
// riscn_core: small multi-cycle RISC core running a latched program word.
//
// A start pulse (in IDLE or DONE) copies prog_in into prog_q and clears the
// register file, pc, steps and timeout. The core then alternates FETCH and
// EXEC, one instruction per two clocks. The run ends on HALT, on the step
// watchdog, or when the last slot executes without a taken branch.
//
// Ports:
//   clock      system clock, rising edge
//   reset      asynchronous, active-low reset
//   start      one-cycle request to load prog_in and run (IDLE/DONE only)
//   prog_in    program, slot i = prog_in[16*i +: 16], slot 0 first
//   ans        current value of R0
//   prog_q     latched program copy
//   pc         current instruction slot
//   busy       high in FETCH or EXEC
//   done       high in DONE
//   timeout    run ended on the step watchdog
//   steps      instructions executed in this run
//   dbg_state  raw FSM state (0 IDLE, 1 FETCH, 2 EXEC, 3 DONE)
//
// Handshake: start is sampled at a rising edge only while busy is low; a
// start seen while busy is dropped. done stays high until the next start.
module riscn_core #(
  parameter int DATA_W    = 16,
  parameter int PC_W      = 2,
  parameter int MAX_STEPS = 64,
  parameter int STEP_W    = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [16*(2**PC_W)-1:0]   prog_in,
  output logic [DATA_W-1:0]         ans,
  output logic [16*(2**PC_W)-1:0]   prog_q,
  output logic [PC_W-1:0]           pc,
  output logic                      busy,
  output logic                      done,
  output logic                      timeout,
  output logic [STEP_W-1:0]         steps,
  output logic [1:0]                dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state;
  logic [15:0]         instr;
  logic [DATA_W-1:0]   rf [4];

  // Instruction fields
  logic [3:0]          op;
  logic [1:0]          rd;
  logic [1:0]          rs;
  logic [7:0]          imm;
  logic [DATA_W-1:0]   imm_z;
  logic [DATA_W-1:0]   imm_s;

  assign op    = instr[15:12];
  assign rd    = instr[11:10];
  assign rs    = instr[9:8];
  assign imm   = instr[7:0];
  assign imm_z = DATA_W'(imm);
  assign imm_s = DATA_W'($signed(imm));

  logic [DATA_W-1:0]   rd_val;
  logic [DATA_W-1:0]   rs_val;
  logic [DATA_W-1:0]   alu_res;
  logic                wr_en;
  logic                is_halt;
  logic                br_taken;
  logic [STEP_W-1:0]   step_nxt;

  always_comb begin
    rd_val  = rf[rd];
    rs_val  = rf[rs];
    alu_res = rd_val;
    wr_en   = 1'b0;
    case (op)
      4'h1: begin alu_res = imm_z;                 wr_en = 1'b1; end
      4'h2: begin alu_res = rd_val + rs_val;       wr_en = 1'b1; end
      4'h3: begin alu_res = rd_val - rs_val;       wr_en = 1'b1; end
      4'h4: begin alu_res = rd_val & rs_val;       wr_en = 1'b1; end
      4'h5: begin alu_res = rd_val | rs_val;       wr_en = 1'b1; end
      4'h6: begin alu_res = rd_val ^ rs_val;       wr_en = 1'b1; end
      4'h7: begin alu_res = rd_val << imm[3:0];    wr_en = 1'b1; end
      4'h8: begin alu_res = rd_val + imm_s;        wr_en = 1'b1; end
      default: begin alu_res = rd_val;             wr_en = 1'b0; end
    endcase
    is_halt  = (op == 4'hF);
    br_taken = (op == 4'h9) && (rd_val != '0);
    step_nxt = steps + 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      instr   <= '0;
      prog_q  <= '0;
      pc      <= '0;
      steps   <= '0;
      timeout <= 1'b0;
      for (int i = 0; i < 4; i++) rf[i] <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            prog_q  <= prog_in;
            pc      <= '0;
            steps   <= '0;
            timeout <= 1'b0;
            for (int i = 0; i < 4; i++) rf[i] <= '0;
            state   <= S_FETCH;
          end
        end
        S_FETCH: begin
          instr <= prog_q[16*pc +: 16];
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (wr_en) rf[rd] <= alu_res;
          steps <= step_nxt;
          // The watchdog outranks branches so an endless loop still stops,
          // but the current instruction's register write above still lands.
          if (is_halt) begin
            state <= S_DONE;
          end else if (step_nxt == STEP_W'(MAX_STEPS)) begin
            timeout <= 1'b1;
            state   <= S_DONE;
          end else if (br_taken) begin
            pc    <= imm[PC_W-1:0];
            state <= S_FETCH;
          end else if (pc == {PC_W{1'b1}}) begin
            // Ran off the last slot: pc holds, no wrap.
            state <= S_DONE;
          end else begin
            pc    <= pc + 1'b1;
            state <= S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign ans       = rf[0];
  assign busy      = (state == S_FETCH) || (state == S_EXEC);
  assign done      = (state == S_DONE);
  assign dbg_state = state;

endmodule
